sha256_msg_sched: RTL and testbench

//  Producer side of the W-word stream consumed by the SHA-256 compression rounds.
//  - Accepts one 512-bit padded message block.
//  - Emits W_0..W_{ROUNDS-1} one word per handshake: W_0..W_15 come from the block,
//    W_16 onward are expanded with sig_0/sig_1.
//  - Sits between the job/nonce block builder and the round engine in the miner datapath.

---
 rtl/sha256_pkg.sv | 31 +++
 rtl/sha256_msg_sched_if.sv | 32 +++
 rtl/sha256_w_next.sv | 21 ++
 rtl/sha256_msg_sched.sv | 108 ++++++++++
 tb/tb_sha256_msg_sched.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha256_pkg
// Brief    : Shared SHA-256 types, round count and sigma primitives.
// Revision : 1.0 - initial release
// ============================================================================
package sha256_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [511:0] block_t;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } sched_state_t;

    localparam int SHA_ROUNDS = 64;
    localparam int WIN_DEPTH  = 16;

    // sigma_0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t sig_0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // sigma_1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t sig_1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_msg_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_sched_if
// Brief    : Block-in / W-word-out handshake bundle of the message scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface sha256_msg_sched_if;
    import sha256_pkg::*;

    logic        blk_valid;
    logic        blk_ready;
    block_t      blk_data;
    logic        w_valid;
    logic        w_ready;
    word_t       w_data;
    logic [5:0]  w_idx;
    logic        w_last;

    // Scheduler side
    modport master (
        input  blk_valid, blk_data, w_ready,
        output blk_ready, w_valid, w_data, w_idx, w_last
    );

    // Block builder / round engine side
    modport slave (
        output blk_valid, blk_data, w_ready,
        input  blk_ready, w_valid, w_data, w_idx, w_last
    );

endinterface
`default_nettype wire

// File: rtl/sha256_w_next.sv
`default_nettype none
// ============================================================================
// Module   : sha256_w_next
// Brief    : Combinational W_{t+16} from W_t, W_{t+1}, W_{t+9}, W_{t+14}.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_w_next
    import sha256_pkg::*;
(
    input  word_t w0_i,
    input  word_t w1_i,
    input  word_t w9_i,
    input  word_t w14_i,
    output word_t w16_o
);

    // Modulo-2^32 sum; carry out is intentionally discarded.
    assign w16_o = sig_1(w14_i) + w9_i + sig_0(w1_i) + w0_i;

endmodule
`default_nettype wire

// File: rtl/sha256_msg_sched.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_sched
// Brief    : Streams W_0..W_{ROUNDS-1} of one padded block via a 16-word window.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = SHA_ROUNDS
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    sha256_msg_sched_if.master  bus
);

    localparam logic [5:0] c_LAST_IDX = 6'(ROUNDS - 1);

    sched_state_t state_q;
    sched_state_t state_d;
    logic [5:0]   idx_q;
    logic [5:0]   idx_d;
    word_t        win_q [WIN_DEPTH];
    word_t        win_d [WIN_DEPTH];

    word_t        w16_next;
    logic         is_last;
    logic         blk_hs;
    logic         w_hs;

    assign is_last       = (idx_q == c_LAST_IDX);
    assign bus.blk_ready = rst_n && !flush && (state_q == S_IDLE);
    assign bus.w_valid   = (state_q == S_STREAM);
    assign bus.w_data    = win_q[0];
    assign bus.w_idx     = idx_q;
    assign bus.w_last    = bus.w_valid && is_last;

    assign blk_hs = bus.blk_valid && bus.blk_ready;
    assign w_hs   = bus.w_valid && bus.w_ready;

    sha256_w_next u_w_next (
        .w0_i  (win_q[0]),
        .w1_i  (win_q[1]),
        .w9_i  (win_q[9]),
        .w14_i (win_q[14]),
        .w16_o (w16_next)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        win_d   = win_q;

        case (state_q)
            S_IDLE: begin
                if (blk_hs) begin
                    state_d = S_STREAM;
                    idx_d   = '0;
                    for (int k = 0; k < WIN_DEPTH; k++) begin
                        win_d[k] = bus.blk_data[32*(WIN_DEPTH-1-k) +: 32];
                    end
                end
            end
            S_STREAM: begin
                if (w_hs) begin
                    // Words appended past ROUNDS-1 are never emitted.
                    for (int k = 0; k < WIN_DEPTH - 1; k++) begin
                        win_d[k] = win_q[k+1];
                    end
                    win_d[WIN_DEPTH-1] = w16_next;
                    if (is_last) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        // Abort drops any same-cycle block or word handshake.
        if (flush) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            for (int k = 0; k < WIN_DEPTH; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_sched
// Brief    : Directed self-checking bench for the SHA-256 message scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_sched;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    sha256_msg_sched_if bus ();
    sha256_msg_sched_if bus16 ();

    sha256_msg_sched #(.ROUNDS(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    sha256_msg_sched #(.ROUNDS(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus16)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    int     last_edges = 0;
    int     last_wait = 0;
    word_t  exp_w [64];
    word_t  got_w [64];
    block_t blk_abc;
    block_t blk_ones;
    block_t blk_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic word_t rr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ssig0(input word_t x);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t ssig1(input word_t x);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model(input block_t b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = ssig1(exp_w[t-2]) + exp_w[t-7] + ssig0(exp_w[t-15]) + exp_w[t-16];
    endtask

    // Called at a negedge; returns at posedge+1 after the accepting edge.
    task automatic load_block(input block_t b, input string tag);
        bit acc = 1'b0;
        int waits = 0;
        bus.blk_data  = b;
        bus.blk_valid = 1'b1;
        while (!acc && waits < 200) begin
            if (bus.blk_ready) acc = 1'b1;
            else begin
                waits++;
                @(negedge clk);
            end
        end
        chk({tag, "_accept"}, 64'(acc), 64'd1);
        last_wait = waits;
        @(posedge clk);
        #1;
        bus.blk_valid = 1'b0;
    endtask

    // Consumes words 0..stop_at-1; returns at the negedge where word stop_at is presented.
    task automatic run_words(input bit rnd, input int stop_at, input string tag);
        int         t = 0;
        int         edges = 0;
        bit         held = 1'b0;
        word_t      hd = '0;
        logic [5:0] hi = '0;
        bus.w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        while (t < stop_at && edges < 1000) begin
            if (held) begin
                chk({tag, "_hold_data"}, 64'(bus.w_data), 64'(hd));
                chk({tag, "_hold_idx"}, 64'(bus.w_idx), 64'(hi));
            end
            chk({tag, "_w_valid"}, 64'(bus.w_valid), 64'd1);
            chk({tag, "_blk_ready"}, 64'(bus.blk_ready), 64'd0);
            if (bus.w_ready) begin
                got_w[t] = bus.w_data;
                chk($sformatf("%s_w%0d", tag, t), 64'(bus.w_data), 64'(exp_w[t]));
                chk($sformatf("%s_idx%0d", tag, t), 64'(bus.w_idx), 64'(t));
                chk($sformatf("%s_last%0d", tag, t), 64'(bus.w_last), 64'(t == 63));
                t++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                hd   = bus.w_data;
                hi   = bus.w_idx;
            end
            @(posedge clk);
            #1;
            edges++;
            bus.w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
        end
        chk({tag, "_count"}, 64'(t), 64'(stop_at));
        last_edges = edges;
    endtask

    task automatic end_checks(input string tag);
        chk({tag, "_end_w_valid"}, 64'(bus.w_valid), 64'd0);
        chk({tag, "_end_blk_ready"}, 64'(bus.blk_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n16;
        blk_abc  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
        blk_ones = '1;
        for (int k = 0; k < 16; k++) blk_cnt[32*(15-k) +: 32] = 32'(k + 1) * 32'h01000193;

        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.blk_valid   = 1'b1;
        bus.blk_data    = blk_abc;
        bus.w_ready     = 1'b0;
        bus16.blk_valid = 1'b0;
        bus16.blk_data  = '0;
        bus16.w_ready   = 1'b0;

        // Reset held with a pending block
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_blk_ready", 64'(bus.blk_ready), 64'd0);
            chk("rst_w_valid", 64'(bus.w_valid), 64'd0);
            chk("rst_w_idx", 64'(bus.w_idx), 64'd0);
            chk("rst_w_last", 64'(bus.w_last), 64'd0);
            chk("rst_w_data", 64'(bus.w_data), 64'd0);
        end
        rst_n         = 1'b1;
        bus.blk_valid = 1'b0;
        #1;
        chk("rel_blk_ready", 64'(bus.blk_ready), 64'd1);
        @(negedge clk);

        // abc block, full rate
        build_model(blk_abc);
        load_block(blk_abc, "abc");
        run_words(1'b0, 64, "abc");
        chk("abc_edges", 64'(last_edges), 64'd64);
        end_checks("abc");
        chk("abc_hand_w0", 64'(got_w[0]), 64'h61626380);
        chk("abc_hand_w15", 64'(got_w[15]), 64'h00000018);
        chk("abc_hand_w16", 64'(got_w[16]), 64'h61626380);
        chk("abc_hand_w17", 64'(got_w[17]), 64'h000F0000);

        // abc block, random back-pressure
        load_block(blk_abc, "bp");
        run_words(1'b1, 64, "bp");
        end_checks("bp");

        // Flush at w_idx 20 colliding with a new block
        load_block(blk_abc, "fl");
        run_words(1'b0, 20, "fl");
        chk("fl_idx_at_flush", 64'(bus.w_idx), 64'd20);
        flush         = 1'b1;
        bus.blk_valid = 1'b1;
        bus.blk_data  = blk_ones;
        #1;
        chk("fl_blk_ready", 64'(bus.blk_ready), 64'd0);
        @(posedge clk);
        #1;
        flush         = 1'b0;
        bus.blk_valid = 1'b0;
        bus.w_ready   = 1'b0;
        @(negedge clk);
        chk("fl_w_valid", 64'(bus.w_valid), 64'd0);
        chk("fl_w_idx", 64'(bus.w_idx), 64'd0);
        chk("fl_blk_ready_after", 64'(bus.blk_ready), 64'd1);
        build_model(blk_cnt);
        load_block(blk_cnt, "post");
        run_words(1'b0, 64, "post");
        end_checks("post");

        // Reset at w_idx 40
        build_model(blk_abc);
        load_block(blk_abc, "mr");
        run_words(1'b0, 40, "mr");
        chk("mr_idx_at_rst", 64'(bus.w_idx), 64'd40);
        rst_n = 1'b0;
        #1;
        chk("mr_blk_ready_low", 64'(bus.blk_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        bus.w_ready = 1'b0;
        @(negedge clk);
        chk("mr_w_valid", 64'(bus.w_valid), 64'd0);
        chk("mr_w_idx", 64'(bus.w_idx), 64'd0);
        chk("mr_w_last", 64'(bus.w_last), 64'd0);
        chk("mr_w_data", 64'(bus.w_data), 64'd0);
        chk("mr_blk_ready", 64'(bus.blk_ready), 64'd1);
        build_model(blk_ones);
        load_block(blk_ones, "mrn");
        run_words(1'b0, 64, "mrn");
        end_checks("mrn");

        // Back-to-back with blk_valid held high
        build_model(blk_abc);
        load_block(blk_abc, "b2b1");
        bus.blk_valid = 1'b1;
        bus.blk_data  = blk_ones;
        run_words(1'b0, 64, "b2b1");
        end_checks("b2b1");
        build_model(blk_ones);
        load_block(blk_ones, "b2b2");
        chk("b2b2_wait", 64'(last_wait), 64'd0);
        run_words(1'b0, 64, "b2b2");
        end_checks("b2b2");

        // ROUNDS=16 build
        build_model(blk_abc);
        bus16.blk_data  = blk_abc;
        bus16.blk_valid = 1'b1;
        chk("r16_blk_ready", 64'(bus16.blk_ready), 64'd1);
        @(posedge clk);
        #1;
        bus16.blk_valid = 1'b0;
        bus16.w_ready   = 1'b1;
        n16 = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus16.w_valid) begin
                if (n16 < 64) begin
                    chk($sformatf("r16_w%0d", n16), 64'(bus16.w_data), 64'(exp_w[n16]));
                    chk($sformatf("r16_idx%0d", n16), 64'(bus16.w_idx), 64'(n16));
                    chk($sformatf("r16_last%0d", n16), 64'(bus16.w_last), 64'(n16 == 15));
                end
                n16++;
            end
        end
        chk("r16_count", 64'(n16), 64'd16);
        chk("r16_blk_ready_end", 64'(bus16.blk_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
